// File: rtl/ttpu_pkg.sv
// Shared FP16 types, constants and the MAC processing-element state encoding.
package ttpu_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO     = 16'h0000;
  localparam fp16_t FP16_ONE      = 16'h3C00;
  localparam int    FP16_SIGN_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REDUCE,
    OUT
  } mac_state_e;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/floating_point_adder.sv
// FP16 adder, round-to-nearest-even, subnormals flushed to zero, LAT-cycle result pipeline.
module floating_point_adder #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic        x_nan, y_nan, x_inf, y_inf, g, r;
    logic [15:0] big, sml;
    logic [13:0] wa, ws;
    logic [14:0] sum;
    logic [10:0] m;
    int          d, e;
    x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'h0);
    x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'h0);
    y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'h0);
    if (x_nan || y_nan) return 16'h7E00;
    if (x_inf && y_inf) return (x[15] == y[15]) ? x : 16'h7E00;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[14:10] == 5'h00 && y[14:10] == 5'h00) return {x[15] & y[15], 15'h0000};
    if (x[14:10] == 5'h00) return y;
    if (y[14:10] == 5'h00) return x;
    if (x[14:0] >= y[14:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d  = int'(big[14:10]) - int'(sml[14:10]);
    wa = {1'b1, big[9:0], 3'b000};
    ws = {1'b1, sml[9:0], 3'b000};
    // Alignment shift keeps every shifted-out bit OR-ed into the sticky position.
    for (int i = 0; i < 31; i++) if (i < d) ws = {1'b0, ws[13:2], ws[1] | ws[0]};
    sum = (big[15] == sml[15]) ? ({1'b0, wa} + {1'b0, ws}) : ({1'b0, wa} - {1'b0, ws});
    if (sum == 15'h0) return 16'h0000;
    e = int'(big[14:10]);
    if (sum[14]) begin
      sum = {1'b0, sum[14:2], sum[1] | sum[0]};
      e   = e + 1;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (!sum[13]) begin
          sum = {sum[13:0], 1'b0};
          e   = e - 1;
        end
      end
    end
    m = {1'b0, sum[12:3]};
    g = sum[2];
    r = sum[1] | sum[0];
    if (e <= 0) return {big[15], 15'h0000};
    if (g && (r || m[0])) m = m + 11'd1;
    if (m[10]) begin
      m = 11'd0;
      e = e + 1;
    end
    if (e >= 31) return {big[15], 5'h1F, 10'h000};
    return {big[15], e[4:0], m[9:0]};
  endfunction

  logic [15:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (en) begin
      pipe_q[0] <= fp16_add(a, b);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/floating_point_multiplayer.sv
// FP16 multiplier, round-to-nearest-even, subnormals flushed to zero, LAT-cycle result pipeline.
module floating_point_multiplayer #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic        s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, g, r;
    logic [21:0] p;
    logic [10:0] m;
    int          e;
    s      = x[15] ^ y[15];
    x_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    y_nan  = (y[14:10] == 5'h1F) && (y[9:0] != 10'h0);
    x_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'h0);
    y_inf  = (y[14:10] == 5'h1F) && (y[9:0] == 10'h0);
    x_zero = (x[14:10] == 5'h00);
    y_zero = (y[14:10] == 5'h00);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return 16'h7E00;
    if (x_inf || y_inf) return {s, 5'h1F, 10'h000};
    if (x_zero || y_zero) return {s, 15'h0000};
    p = {1'b1, x[9:0]} * {1'b1, y[9:0]};
    e = int'(x[14:10]) + int'(y[14:10]) - 15;
    if (p[21]) begin
      m = {1'b0, p[20:11]};
      g = p[10];
      r = |p[9:0];
      e = e + 1;
    end else begin
      m = {1'b0, p[19:10]};
      g = p[9];
      r = |p[8:0];
    end
    if (g && (r || m[0])) m = m + 11'd1;
    if (m[10]) begin
      m = 11'd0;
      e = e + 1;
    end
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return {s, 5'h1F, 10'h000};
    return {s, e[4:0], m[9:0]};
  endfunction

  logic [15:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (en) begin
      pipe_q[0] <= fp16_mul(a, b);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/valid_tag_pipe.sv
// Reset-clearable delay line carrying a valid bit and a small tag alongside a datapath pipeline.
module valid_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             vld_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/fp_mac_pe.sv
// FP16 multiply-accumulate PE: ADD_LAT interleaved partial sums reduced to one dot product per vector.
// Build option FP_MAC_RELU_EN clamps negative non-NaN results to +0.0.
module fp_mac_pe
  import ttpu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int LANE_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam int TMR_W     = 16;
  localparam int DRAIN_CYC = MUL_LAT + ADD_LAT;

  function automatic fp16_t fp16_relu(input fp16_t x);
`ifdef FP_MAC_RELU_EN
    return (x[FP16_SIGN_BIT] && !fp16_is_nan(x)) ? FP16_ZERO : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  mac_state_e         state_q;
  logic               in_ready_q, out_valid_q, busy_q;
  fp16_t              out_data_q;
  logic [CNT_W-1:0]   out_count_q, count_q;
  logic [LANE_W-1:0]  ptr_q, red_lane_q;
  logic [TMR_W-1:0]   tmr_q;
  fp16_t              psum_q   [ADD_LAT];
  fp16_t              psum_byp [ADD_LAT];

  logic               accept, drain_end, red_step, red_done;
  logic [LANE_W-1:0]  acc_tag, red_idx, mul_tag, add_tag;
  logic               mul_vld, add_vld;
  fp16_t              mul_res, add_res, add_a, add_b;

  assign accept  = in_valid & in_ready_q;
  assign acc_tag = (state_q == IDLE) ? '0 : ptr_q;

  floating_point_multiplayer #(.LAT(MUL_LAT)) u_mul (
    .clk(clk), .en(1'b1), .a(in_a), .b(in_b), .result(mul_res)
  );

  valid_tag_pipe #(.DEPTH(MUL_LAT), .TAG_W(LANE_W)) u_mul_pipe (
    .clk(clk), .reset(reset), .vld_i(accept), .tag_i(acc_tag), .vld_o(mul_vld), .tag_o(mul_tag)
  );

  floating_point_adder #(.LAT(ADD_LAT)) u_add (
    .clk(clk), .en(1'b1), .a(add_a), .b(add_b), .result(add_res)
  );

  valid_tag_pipe #(.DEPTH(ADD_LAT), .TAG_W(LANE_W)) u_add_pipe (
    .clk(clk), .reset(reset), .vld_i(mul_vld), .tag_i(mul_tag), .vld_o(add_vld), .tag_o(add_tag)
  );

  // Lane reads see a same-cycle adder write-back (write-before-read).
  always_comb begin
    for (int i = 0; i < ADD_LAT; i++)
      psum_byp[i] = (add_vld && add_tag == LANE_W'(i)) ? add_res : psum_q[i];
  end

  // The first reduction add is issued in the last drain cycle so the final sum lands at OUT entry.
  always_comb begin
    drain_end = (state_q == DRAIN) && (tmr_q == TMR_W'(DRAIN_CYC - 1));
    red_step  = (state_q == REDUCE) && (tmr_q == TMR_W'(ADD_LAT - 1));
    red_done  = (red_lane_q == LANE_W'(ADD_LAT - 1));
    red_idx   = drain_end ? LANE_W'(1) : red_lane_q + 1'b1;
    add_a     = mul_res;
    add_b     = psum_byp[mul_tag];
    if ((drain_end && ADD_LAT > 1) || (red_step && !red_done)) begin
      add_a = psum_byp[red_idx];
      add_b = drain_end ? psum_byp[0] : add_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= FP16_ZERO;
      out_count_q <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      red_lane_q  <= '0;
      tmr_q       <= '0;
      for (int i = 0; i < ADD_LAT; i++) psum_q[i] <= FP16_ZERO;
    end else begin
      if (add_vld) psum_q[add_tag] <= add_res;
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            count_q <= (state_q == IDLE) ? CNT_W'(1) : sat_inc(count_q);
            ptr_q   <= (acc_tag == LANE_W'(ADD_LAT - 1)) ? '0 : acc_tag + 1'b1;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            if (in_last) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DRAIN: begin
          tmr_q <= tmr_q + 1'b1;
          if (drain_end) begin
            tmr_q <= '0;
            if (ADD_LAT == 1) begin
              out_data_q  <= fp16_relu(psum_byp[0]);
              out_count_q <= count_q;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              red_lane_q <= LANE_W'(1);
              state_q    <= REDUCE;
            end
          end
        end
        REDUCE: begin
          tmr_q <= red_step ? '0 : tmr_q + 1'b1;
          if (red_step) begin
            if (red_done) begin
              out_data_q  <= fp16_relu(add_res);
              out_count_q <= count_q;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              red_lane_q <= red_idx;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            for (int i = 0; i < ADD_LAT; i++) psum_q[i] <= FP16_ZERO;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_mac_pe.sv
// Directed bench for fp_mac_pe: vector table plus backpressure and mid-vector reset sequences.
module tb_fp_mac_pe;

  localparam int MUL_LAT   = 2;
  localparam int ADD_LAT   = 4;
  localparam int CNT_W     = 16;
  // Clock edges from the edge accepting in_last to the edge raising out_valid.
  localparam int LAT_EDGES = MUL_LAT + ADD_LAT * ADD_LAT;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_last;
  logic [15:0]      in_a, in_b;
  logic             out_valid, out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  fp_mac_pe #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] relu_exp(input logic [15:0] x);
`ifdef FP_MAC_RELU_EN
    if (x[15] && !(x[14:10] == 5'h1F && x[9:0] != 10'h0)) return 16'h0000;
`endif
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      output logic rdy_now);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    rdy_now  = in_ready;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          k;
    bit          gaps;
    logic [15:0] exp_data;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic             r, all_rdy, stable, rdy_low, saw;
    logic [15:0]      d0;
    logic [CNT_W-1:0] c0;
    int               n;

    vecs[0] = '{16'h3C00, 16'h4000, 1, 1'b0, 16'h4000, 1};
    vecs[1] = '{16'h3C00, 16'h3C00, 8, 1'b0, 16'h4800, 8};
    vecs[2] = '{16'h4000, 16'h3E00, 5, 1'b1, 16'h4B80, 5};
    vecs[3] = '{16'h3C00, 16'hC200, 1, 1'b0, 16'hC200, 1};
    vecs[4] = '{16'h7E00, 16'h3C00, 1, 1'b0, 16'h7E00, 1};
    vecs[5] = '{16'h4000, 16'h4000, 3, 1'b0, 16'h4A00, 3};
    vecs[6] = '{16'h4000, 16'hBC00, 2, 1'b1, 16'hC400, 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);

    for (int v = 0; v < 7; v++) begin
      all_rdy = 1'b1;
      for (int i = 0; i < vecs[v].k; i++) begin
        if (vecs[v].gaps) repeat ($urandom_range(3, 0)) tick();
        send(vecs[v].a, vecs[v].b, (i == vecs[v].k - 1), r);
        if (!r) all_rdy = 1'b0;
        if (i == 0) check($sformatf("v%0d_busy", v), busy, 1);
      end
      wait_out(n);
      check($sformatf("v%0d_latency", v), n, LAT_EDGES);
      check($sformatf("v%0d_data", v), out_data, relu_exp(vecs[v].exp_data));
      check($sformatf("v%0d_count", v), out_count, vecs[v].exp_cnt);
      check($sformatf("v%0d_in_ready", v), all_rdy, 1);
      tick();
    end

    // Output backpressure, then a pair offered during the output handshake.
    out_ready = 1'b0;
    send(16'h3C00, 16'h3C00, 1'b0, r);
    send(16'h3C00, 16'h3C00, 1'b1, r);
    wait_out(n);
    d0       = out_data;
    c0       = out_count;
    stable   = 1'b1;
    rdy_low  = 1'b1;
    in_valid = 1'b1;
    in_a     = 16'h3C00;
    in_b     = 16'h4000;
    in_last  = 1'b1;
    repeat (10) begin
      tick();
      if (out_data !== d0 || out_count !== c0 || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("bp_data", d0, 16'h4000);
    check("bp_count", c0, 2);
    check("bp_stable", stable, 1);
    check("bp_in_ready_low", rdy_low, 1);
    out_ready = 1'b1;
    check("hs_in_ready", in_ready, 0);
    tick();
    check("hs_out_valid_drop", out_valid, 0);
    check("hs_in_ready_back", in_ready, 1);
    check("hs_busy_idle", busy, 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("hs_next_busy", busy, 1);
    wait_out(n);
    check("hs_next_latency", n, LAT_EDGES);
    check("hs_next_data", out_data, 16'h4000);
    check("hs_next_count", out_count, 1);
    tick();

    // Asynchronous reset in the middle of accumulation.
    repeat (3) send(16'h3C00, 16'h3C00, 1'b0, r);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_count", out_count, 0);
    tick();
    reset = 1'b0;
    saw   = 1'b0;
    repeat (30) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("mid_rst_no_output", saw, 0);
    send(16'h3C00, 16'h3C00, 1'b1, r);
    wait_out(n);
    check("post_rst_data", out_data, 16'h3C00);
    check("post_rst_count", out_count, 1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
